// File: rtl/sha3512_pkg.sv
// ============================================================================
//  Module      : sha3512_pkg
//  Description : Shared constants, padding bytes and padder state encoding
//                for the SHA3-512 message absorption path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha3512_pkg;

   localparam int RATE_BITS       = 576;
   localparam int RATE_BYTES      = 72;
   localparam int WORDS_PER_BLOCK = 9;

   localparam logic [7:0] PAD_SUFFIX = 8'h06;
   localparam logic [7:0] PAD_END    = 8'h80;

   // Block made only of padding, used when the message ends exactly on a
   // rate boundary.
   localparam logic [RATE_BITS-1:0] PAD_ONLY_BLOCK = {PAD_END, 560'b0, PAD_SUFFIX};

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_PADBLK = 2'd2,
      ST_DONE   = 2'd3
   } padState_t;

endpackage

`default_nettype wire

// File: rtl/sha3512_pad_insert.sv
// ============================================================================
//  Module      : sha3512_pad_insert
//  Description : Combinational zero-mask and SHA-3 padding insertion. Keeps
//                bytes below inLen, writes the domain suffix at byte inLen and
//                ORs the end marker into byte 71. inLen = 71 merges both into
//                0x86; inLen >= 72 passes the block through unpadded.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha3512_pad_insert
   import sha3512_pkg::*;
(
   input  logic [RATE_BITS-1:0] inBlock,
   input  logic [6:0]           inLen,
   output logic [RATE_BITS-1:0] outBlock
);

   localparam logic [6:0] c_RATE_LEN = 7'(RATE_BYTES);

   // Per-byte select between message byte, suffix byte and zero, then end marker
   always_comb begin
      outBlock = '0;
      for (int j = 0; j < RATE_BYTES; j++) begin
         if (7'(j) < inLen) begin
            outBlock[8*j +: 8] = inBlock[8*j +: 8];
         end else if (7'(j) == inLen) begin
            outBlock[8*j +: 8] = PAD_SUFFIX;
         end
      end
      if (inLen < c_RATE_LEN) begin
         outBlock[RATE_BITS-1 -: 8] = outBlock[RATE_BITS-1 -: 8] | PAD_END;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sha3512_block_padder.sv
// ============================================================================
//  Module      : sha3512_block_padder
//  Description : Packs 64-bit little-endian message words into 576-bit rate
//                blocks, applies SHA-3 padding and strobes each block into
//                the permutation core while honouring its busy flag.
//                Optional: define SHA3512_PADDER_BLKCNT_EN to add the 16-bit
//                outBlockCount strobe counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha3512_block_padder
   import sha3512_pkg::*;
#(
   parameter int WORD_W = 64
)(
   input  logic                 inClk,
   input  logic                 inInit,
   input  logic                 inWordValid,
   input  logic [WORD_W-1:0]    inWord,
   input  logic                 inLast,
   input  logic [3:0]           inWordBytes,
   output logic                 outWordReady,
   output logic [RATE_BITS-1:0] outBlock,
   output logic                 outBlockWr,
   input  logic                 inCoreBusy,
   output logic                 outDone
`ifdef SHA3512_PADDER_BLKCNT_EN
   ,
   output logic [15:0]          outBlockCount
`endif
);

   localparam logic [3:0] c_LAST_SLOT = 4'(WORDS_PER_BLOCK - 1);
   localparam logic [6:0] c_RATE_LEN  = 7'(RATE_BYTES);

   padState_t            r_state;
   logic [3:0]           r_wcnt;
   logic [RATE_BITS-1:0] r_buf;
   logic                 r_final;
   logic                 r_padPending;
   logic                 r_wrPrev;

   logic                 w_accept;
   logic                 w_blockWr;
   logic [3:0]           w_bytes;
   logic [6:0]           w_len;
   logic [RATE_BITS-1:0] w_merged;
   logic [RATE_BITS-1:0] w_padded;

   assign outWordReady = (r_state == ST_FILL) || (r_state == ST_DONE);
   assign outDone      = (r_state == ST_DONE);
   assign outBlock     = r_buf;
   assign w_accept     = inWordValid && outWordReady;

   // Strobe only when the core is idle and the previous cycle had no strobe,
   // since the core raises busy one cycle after a write.
   assign w_blockWr = ((r_state == ST_ISSUE) || (r_state == ST_PADBLK)) &&
                      !inCoreBusy && !r_wrPrev && !inInit;
   assign outBlockWr = w_blockWr;

   // Clamp the byte count of the last word and form the block's message length
   assign w_bytes = (inWordBytes > 4'd8) ? 4'd8 : inWordBytes;
   assign w_len   = {r_wcnt, 3'b000} + {3'b000, w_bytes};

   // Drop the incoming word into slot r_wcnt of the buffer
   always_comb begin
      w_merged = r_buf;
      for (int s = 0; s < WORDS_PER_BLOCK; s++) begin
         if (r_wcnt == 4'(s)) begin
            w_merged[WORD_W*s +: WORD_W] = inWord;
         end
      end
   end

   sha3512_pad_insert u_padInsert (
      .inBlock  (w_merged),
      .inLen    (w_len),
      .outBlock (w_padded)
   );

   // Main FSM: fill slots, pad on last word, issue block(s) to the core
   always_ff @(posedge inClk) begin
      if (inInit) begin
         r_state      <= ST_FILL;
         r_wcnt       <= 4'd0;
         r_buf        <= '0;
         r_final      <= 1'b0;
         r_padPending <= 1'b0;
         r_wrPrev     <= 1'b0;
      end else begin
         r_wrPrev <= w_blockWr;
         case (r_state)
            ST_FILL, ST_DONE: begin
               if (w_accept) begin
                  r_wcnt <= r_wcnt + 4'd1;
                  if (inLast) begin
                     r_buf        <= w_padded;
                     r_final      <= (w_len < c_RATE_LEN);
                     r_padPending <= (w_len == c_RATE_LEN);
                     r_state      <= ST_ISSUE;
                  end else if (r_wcnt == c_LAST_SLOT) begin
                     r_buf        <= w_merged;
                     r_final      <= 1'b0;
                     r_padPending <= 1'b0;
                     r_state      <= ST_ISSUE;
                  end else begin
                     r_buf   <= w_merged;
                     r_state <= ST_FILL;
                  end
               end
            end
            ST_ISSUE: begin
               if (w_blockWr) begin
                  r_wcnt <= 4'd0;
                  if (r_final) begin
                     r_buf   <= '0;
                     r_state <= ST_DONE;
                  end else if (r_padPending) begin
                     r_buf        <= PAD_ONLY_BLOCK;
                     r_padPending <= 1'b0;
                     r_state      <= ST_PADBLK;
                  end else begin
                     r_buf   <= '0;
                     r_state <= ST_FILL;
                  end
               end
            end
            ST_PADBLK: begin
               if (w_blockWr) begin
                  r_wcnt  <= 4'd0;
                  r_buf   <= '0;
                  r_state <= ST_DONE;
               end
            end
            default: r_state <= ST_FILL;
         endcase
      end
   end

`ifdef SHA3512_PADDER_BLKCNT_EN
   logic [15:0] r_blkCount;

   // Count strobes; restart when a new message begins after DONE
   always_ff @(posedge inClk) begin
      if (inInit) begin
         r_blkCount <= 16'd0;
      end else if (w_blockWr) begin
         r_blkCount <= r_blkCount + 16'd1;
      end else if (w_accept && (r_state == ST_DONE)) begin
         r_blkCount <= 16'd0;
      end
   end

   assign outBlockCount = r_blkCount;
`endif

endmodule

`default_nettype wire

// File: doc/sha3512_block_padder.md
# sha3512_block_padder

Upstream message-absorption stage for the SHA3-512 coprocessor. It accepts the message as a stream of little-endian 64-bit words and assembles them into 576-bit rate blocks. It applies SHA-3 padding (domain suffix 0x06, final bit 0x80) and writes each block into the core with a one-cycle write strobe, honouring the core's busy flag. Its `outBlock`/`outBlockWr` drive the core's `inData`/`inDataWr`, and `inCoreBusy` is driven by the core's `outBusy`.

## Interface
- `WORD_W`, 64: input word width; only 64 is supported.
- `inClk` in 1: clock; all logic on the rising edge.
- `inInit` in 1: reset, synchronous, active-high; shared with the core's `inInit`.
- `inWordValid` in 1: `inWord` is valid this cycle.
- `inWord` in 64: message word; message byte k of the word is `inWord[8k+7:8k]`.
- `inLast` in 1: qualifies the final word of the message.
- `inWordBytes` in 4: valid bytes in the last word, 0..8; read only with `inLast`; values above 8 are treated as 8.
- `outWordReady` out 1: padder accepts a word this cycle.
- `outBlock` out 576: rate block, little-endian; byte j is `[8j+7:8j]`.
- `outBlockWr` out 1: one-cycle write strobe to the core.
- `inCoreBusy` in 1: core busy.
- `outDone` out 1: the final padded block has been issued.

## Operation
- States:
  - FILL: `outWordReady`=1. An accepted word (valid & ready) goes to word slot `wcnt` (0..8), and `wcnt` increments.
  - ISSUE: `outWordReady`=0. Waits for the core to be free, then strobes the block.
  - PADBLK: an extra all-padding block is pending.
  - DONE: `outDone`=1, `outWordReady`=1.
- Non-last word completing slot 8 -> ISSUE.
- Last word: let n = 8·wcnt + `inWordBytes`, the message bytes held in the block.
  - Bytes ≥ n are zeroed; bytes beyond `inWordBytes` in the last word are ignored.
  - If n < 72: byte n |= 0x06, byte 71 |= 0x80, then ISSUE (final).
  - n = 71 gives byte 71 = 0x86.
  - n = 72: issue the full block unpadded (ISSUE, non-final), then PADBLK.
  - The PADBLK block is 0x06 in byte 0, 0x80 in byte 71, zero elsewhere.
- ISSUE/PADBLK: `outBlockWr`=1 in the first cycle with `inCoreBusy`=0 and no strobe in the previous cycle (guard cycle, because the core raises busy one cycle after a write).
- After a strobe:
  - The buffer clears and `wcnt` is set to 0.
  - The next state is FILL for a non-final block, PADBLK for a pending padding block, or DONE after the final block.
- DONE: the first accepted word starts a new message (clears `outDone`, behaves as in FILL).
- `inWordValid` while `outWordReady`=0: ignored; the sender must hold the word.
- `inInit` at any time: the partial block is discarded and no strobe is issued that cycle.

## Timing
- Reset values (cycle after `inInit`):
  - state FILL, `wcnt`=0.
  - `outWordReady`=1.
  - `outBlockWr`=0, `outBlock`=0.
  - `outDone`=0.
  - block counter = 0 (when the block counter is compiled in).
- Latency: word accepted at edge t, completing a block with the core idle -> `outBlockWr` high in cycle t+1.
- `outBlock` is valid in the strobe cycle; afterwards it is undefined until the next strobe.
- Throughput is bounded by the core: at most one strobe per 2 cycles, in practice one per core permutation.
- `outDone` rises in the cycle after the final strobe.

## Configuration
- `SHA3512_PADDER_BLKCNT_EN` defined:
  - Adds output port `outBlockCount` (16 bits) counting strobes since `inInit`.
  - The count wraps from 0xFFFF to 0.
  - The count clears on the first word of a new message accepted in DONE.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `sha3512_pkg`:
  - `RATE_BITS`=576, `RATE_BYTES`=72, `WORDS_PER_BLOCK`=9.
  - `PAD_SUFFIX`=8'h06, `PAD_END`=8'h80.
  - Padder state enum.
- Sub-module `sha3512_pad_insert`:
  - Combinational.
  - Takes the block buffer and n (7 bits); returns the zero-masked, padded block.
  - Handles the n=71 merge (0x86).

## Test plan
- Empty message (single last word, `inWordBytes`=0) -> one strobe; `outBlock` byte0=0x06, byte71=0x80, all other bytes 0; `outDone`=1 next cycle.
- "abc" (`inWord`=64'h636261, bytes=3, last) -> `outBlock[31:0]`=32'h06636261, `outBlock[575:568]`=8'h80, one strobe.
- 71-byte message -> one strobe with byte71=0x86 and bytes 0..70 equal to the message.
- 72-byte message (9 words, last with bytes=8) -> two strobes: the raw block, then {8'h80, 560'b0, 8'h06}; counter=2 when compiled in.
- 144-byte message with `inCoreBusy` held high for 30 cycles after the first strobe -> `outWordReady` stays 0 once the second block is full, no strobe while busy, strobe in the cycle after busy falls, then a third padding-only block.
- `inInit` after 5 words of a block -> no strobe; `wcnt`=0, `outDone`=0; a following "abc" yields the block above.
